if_id_stage_buf: RTL and testbench
==================================

// Module: if_id_stage_buf
// PURPOSE
//  Parametrised successor to the fetch/decode pipeline register. Adds valid/ready handshaking,
//  an optional 2-entry skid buffer, and an exception lock on the fetch side.
//  Sits between the fetch stage (F) and the decode stage (D).
//  Carries instr/pc/pc+4 and the fetch exception code.
//  Supports flush from the hazard unit and from EX/MEM exception entry.
// PARAMETERS
//  XLEN     `XLEN_64b  width encoding; data width DW = 1<<(XLEN+4)
//  EXC_W    4          exception code width
//  NO_E_VAL `NO_E      code meaning "no exception"
// PORTS
//  i_clk               in   1      clock
//  i_rst               in   1      asynchronous reset, active-high
//  i_clk_en            in   1      global stage enable
//  i_flush             in   1      hazard flush (branch/jump)
//  i_flush_exception_m in   1      flush issued after a valid exception was entered in MEM
//  i_valid_f           in   1      F offers an entry
//  o_ready_f           out  1      buffer can accept an entry
//  i_instr_f           in   DW     fetched instruction
//  i_pc_f              in   DW     PC of the fetched instruction
//  i_pc_p4_f           in   DW     PC+4
//  i_exception_code_f  in   EXC_W  fetch exception code
//  o_valid_d           out  1      D-side entry valid
//  i_ready_d           in   1      D consumes the entry (low = stall)
//  o_instr_d           out  DW     head entry: instruction
//  o_pc_d              out  DW     head entry: PC
//  o_pc_p4_d           out  DW     head entry: PC+4
//  o_exception_code_d  out  EXC_W  head entry: exception code
//  o_exc_lock          out  1      exception entry captured; intake blocked
//  o_count             out  2      occupancy, 0..2
// BEHAVIOUR
//  - Reset (async): valid=0, count=0, lock=0; all data outputs 0; exc code = NO_E_VAL.
//  - Accept = i_valid_f & o_ready_f & i_clk_en.
//  - Consume = o_valid_d & i_ready_d & i_clk_en.
//  - i_clk_en=0: state frozen; flush still applies.
//  - Latency: 1 cycle from accept into an empty buffer to o_valid_d=1.
//  - Entries leave in FIFO order; no duplication, no loss except by flush.
//  - Head outputs stay stable while o_valid_d=1 and i_ready_d=0.
//  - Flush (i_flush | i_flush_exception_m): synchronous; highest priority below reset.
//    * Clears valid, count and lock; zeroes data; sets exc code to NO_E_VAL.
//    * An accept in the same cycle is discarded.
//  - Exception lock: set when an accepted entry has code != NO_E_VAL.
//    * While lock=1: o_ready_f=0.
//    * The exception entry still drains to D normally.
//    * Lock is cleared only by a flush or by reset.
//  - Empty head: o_valid_d=0; data outputs hold 0 / NO_E_VAL.
//  - Skid mode state machine (macro defined). Entries: main (head) and skid.
//    * EMPTY: accept -> ONE (load main).
//    * ONE: accept & !consume -> FULL (load skid).
//    * ONE: accept & consume -> ONE (main <= input).
//    * ONE: consume & !accept -> EMPTY.
//    * FULL: consume -> ONE (main <= skid). Accept is impossible in FULL.
//    * o_ready_f = !FULL & !lock, driven purely from registers (no i_ready_d path).
//  - Single mode (macro undefined): one entry only; count is 0..1.
//    * o_ready_f = (!valid | i_ready_d) & !lock (combinational path).
//    * Accept & consume in the same cycle replaces the entry.
// CONFIGURATION
//  IF_ID_SKID_EN defined:   2-entry skid buffer; o_ready_f is registered; full throughput
//                           with no combinational ready path from D to F.
//  IF_ID_SKID_EN undefined: single register; o_count never exceeds 1; smaller area.
// TESTING
//  1. Reset mid-stream: assert i_rst asynchronously with count=2
//     -> o_valid_d=0, o_count=0, o_pc_d=0 and o_exception_code_d=NO_E before the next edge.
//  2. Streaming: i_valid_f=1 every cycle with pc 0x0,0x4,0x8, i_ready_d=1
//     -> o_pc_d=0x0,0x4,0x8 one cycle later, no bubbles.
//  3. Stall (skid mode): i_ready_d=0 for 3 cycles during a stream
//     -> o_count reaches 2; o_ready_f=0; o_pc_d held; on release, order 0x4 then 0x8.
//  4. Exception lock: accept pc 0x10 with code 0x1
//     -> o_exc_lock=1, o_ready_f=0; 0x10 reaches D with code 0x1; later fetches rejected.
//  5. Flush during accept: i_flush=1 with i_valid_f=1 (pc 0x20) while count=1
//     -> next cycle: count=0, o_valid_d=0, lock=0; 0x20 never appears at D.
//  6. Clock enable: i_clk_en=0 with i_valid_f=1 and i_ready_d=1
//     -> no state change; then i_flush_exception_m=1 -> buffer cleared.

Source files
------------

// File: rtl/if_id_stage_buf_if.sv
// ---------------------------------------------------------------------------
// if_id_stage_buf_if
// Bundles every non-clock/reset signal of the fetch/decode stage buffer.
//   slave  : the buffer itself (samples F-side inputs, drives D-side outputs)
//   master : whoever drives the buffer (fetch/decode/hazard logic, bench)
// Signals
//   i_clk_en             global stage enable
//   i_flush              hazard flush (branch/jump)
//   i_flush_exception_m  flush after an exception was entered in MEM
//   i_valid_f/o_ready_f  fetch-side handshake
//   i_instr_f/i_pc_f/i_pc_p4_f/i_exception_code_f  fetch-side payload
//   o_valid_d/i_ready_d  decode-side handshake
//   o_instr_d/o_pc_d/o_pc_p4_d/o_exception_code_d  head entry payload
//   o_exc_lock           exception entry captured, intake blocked
//   o_count              occupancy 0..2
// ---------------------------------------------------------------------------
interface if_id_stage_buf_if #(
    parameter int DW    = 64,
    parameter int EXC_W = 4
);
    logic             i_clk_en;
    logic             i_flush;
    logic             i_flush_exception_m;
    logic             i_valid_f;
    logic             o_ready_f;
    logic [DW-1:0]    i_instr_f;
    logic [DW-1:0]    i_pc_f;
    logic [DW-1:0]    i_pc_p4_f;
    logic [EXC_W-1:0] i_exception_code_f;
    logic             o_valid_d;
    logic             i_ready_d;
    logic [DW-1:0]    o_instr_d;
    logic [DW-1:0]    o_pc_d;
    logic [DW-1:0]    o_pc_p4_d;
    logic [EXC_W-1:0] o_exception_code_d;
    logic             o_exc_lock;
    logic [1:0]       o_count;

    modport slave (
        input  i_clk_en, i_flush, i_flush_exception_m,
        input  i_valid_f, i_instr_f, i_pc_f, i_pc_p4_f, i_exception_code_f,
        input  i_ready_d,
        output o_ready_f, o_valid_d,
        output o_instr_d, o_pc_d, o_pc_p4_d, o_exception_code_d,
        output o_exc_lock, o_count
    );

    modport master (
        output i_clk_en, i_flush, i_flush_exception_m,
        output i_valid_f, i_instr_f, i_pc_f, i_pc_p4_f, i_exception_code_f,
        output i_ready_d,
        input  o_ready_f, o_valid_d,
        input  o_instr_d, o_pc_d, o_pc_p4_d, o_exception_code_d,
        input  o_exc_lock, o_count
    );
endinterface

// File: rtl/if_id_stage_buf.sv
// ---------------------------------------------------------------------------
// if_id_stage_buf
// Fetch -> decode pipeline buffer with valid/ready handshaking, flush and an
// exception lock that stops intake once an excepting fetch was accepted.
// Build option: define IF_ID_SKID_EN for a 2-entry skid buffer whose
// o_ready_f comes only from registers; undefined gives a single register
// with a combinational ready path from D back to F.
// Ports
//   i_clk  clock
//   i_rst  asynchronous reset, active-high
//   bus    if_id_stage_buf_if.slave (handshakes, payloads, flush, status)
// Parameters
//   XLEN      width encoding, data width DW = 1 << (XLEN+4)
//   EXC_W     exception code width
//   NO_E_VAL  exception code meaning "no exception"
// ---------------------------------------------------------------------------
`ifndef XLEN_64b
`define XLEN_64b 2
`endif
`ifndef NO_E
`define NO_E 4'h0
`endif

module if_id_stage_buf #(
    parameter int               XLEN     = `XLEN_64b,
    parameter int               EXC_W    = 4,
    parameter logic [EXC_W-1:0] NO_E_VAL = `NO_E
) (
    input logic              i_clk,
    input logic              i_rst,
    if_id_stage_buf_if.slave bus
);
    localparam int DW = 1 << (XLEN + 4);

    typedef struct packed {
        logic [DW-1:0]    instr;
        logic [DW-1:0]    pc;
        logic [DW-1:0]    pc_p4;
        logic [EXC_W-1:0] exc;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    entry_t main_e;
    entry_t in_e;
    entry_t clear_e;
    logic   lock;
    logic   flush;
    logic   accept;
    logic   consume;
    logic   ready_f;
    logic   valid_d;

    assign in_e    = {bus.i_instr_f, bus.i_pc_f, bus.i_pc_p4_f, bus.i_exception_code_f};
    assign clear_e = {{(3*DW){1'b0}}, NO_E_VAL};

    // Flush is not gated by the clock enable.
    assign flush   = bus.i_flush | bus.i_flush_exception_m;
    assign accept  = bus.i_valid_f & ready_f & bus.i_clk_en;
    assign consume = valid_d & bus.i_ready_d & bus.i_clk_en;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_EMPTY;
        end else if (flush) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (accept) state_nxt = S_ONE;
            S_ONE: begin
`ifdef IF_ID_SKID_EN
                if (accept && !consume) state_nxt = S_FULL;
                else if (consume && !accept) state_nxt = S_EMPTY;
`else
                // Single mode: accept while occupied implies consume.
                if (consume && !accept) state_nxt = S_EMPTY;
`endif
            end
            S_FULL:  if (consume) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        valid_d = (state != S_EMPTY);
`ifdef IF_ID_SKID_EN
        ready_f = (state != S_FULL) && !lock;
`else
        ready_f = (!valid_d || bus.i_ready_d) && !lock;
`endif
        bus.o_ready_f          = ready_f;
        bus.o_valid_d          = valid_d;
        bus.o_instr_d          = main_e.instr;
        bus.o_pc_d             = main_e.pc;
        bus.o_pc_p4_d          = main_e.pc_p4;
        bus.o_exception_code_d = main_e.exc;
        bus.o_exc_lock         = lock;
        bus.o_count            = state;
    end

`ifdef IF_ID_SKID_EN
    entry_t skid_e;

    // Skid slot fills only when the head is stalled and drains into the head.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            skid_e <= clear_e;
        end else if (flush) begin
            skid_e <= clear_e;
        end else if (accept && state == S_ONE && !consume) begin
            skid_e <= in_e;
        end else if (consume && state == S_FULL) begin
            skid_e <= clear_e;
        end
    end
`endif

    // Head entry and exception lock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            main_e <= clear_e;
            lock   <= 1'b0;
        end else if (flush) begin
            main_e <= clear_e;
            lock   <= 1'b0;
        end else begin
            if (accept && bus.i_exception_code_f != NO_E_VAL) begin
                lock <= 1'b1;
            end
            if (accept && (state == S_EMPTY || consume)) begin
                main_e <= in_e;
            end else if (consume) begin
`ifdef IF_ID_SKID_EN
                main_e <= (state == S_FULL) ? skid_e : clear_e;
`else
                main_e <= clear_e;
`endif
            end
        end
    end
endmodule

// File: tb/tb_if_id_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage_buf
// Directed bench for if_id_stage_buf; expectations follow the build option
// IF_ID_SKID_EN. Uses NO_E_VAL = 4'hE so the "no exception" code is nonzero.
// ---------------------------------------------------------------------------
module tb_if_id_stage_buf;
    localparam logic [3:0] NOE = 4'hE;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    if_id_stage_buf_if #(.DW(64), .EXC_W(4)) bus ();

    if_id_stage_buf #(.XLEN(2), .EXC_W(4), .NO_E_VAL(NOE)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk_instr(input logic [63:0] pc);
        return {32'hC0DE_0000, pc[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [63:0] pc, input logic [3:0] exc);
        bus.i_valid_f          = v;
        bus.i_pc_f             = pc;
        bus.i_pc_p4_f          = pc + 64'd4;
        bus.i_instr_f          = mk_instr(pc);
        bus.i_exception_code_f = exc;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus.i_clk_en            = 1'b1;
        bus.i_flush             = 1'b0;
        bus.i_flush_exception_m = 1'b0;
        bus.i_ready_d           = 1'b0;
        offer(1'b0, 64'h0, NOE);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_valid", bus.o_valid_d, 1'b0);
        chk("rst_count", bus.o_count, 2'd0);
        chk("rst_lock", bus.o_exc_lock, 1'b0);
        chk("rst_pc", bus.o_pc_d, 64'h0);
        chk("rst_exc", bus.o_exception_code_d, NOE);
        chk("rst_ready", bus.o_ready_f, 1'b1);

        // Streaming
        bus.i_ready_d = 1'b1;
        offer(1'b1, 64'h0, NOE);
        tick();
        chk("str0_valid", bus.o_valid_d, 1'b1);
        chk("str0_pc", bus.o_pc_d, 64'h0);
        offer(1'b1, 64'h4, NOE);
        tick();
        chk("str1_pc", bus.o_pc_d, 64'h4);
        chk("str1_count", bus.o_count, 2'd1);
        offer(1'b1, 64'h8, NOE);
        tick();
        chk("str2_pc", bus.o_pc_d, 64'h8);
        chk("str2_pcp4", bus.o_pc_p4_d, 64'hC);
        chk("str2_instr", bus.o_instr_d, 64'hC0DE_0000_0000_0008);
        offer(1'b0, 64'h0, NOE);
        tick();
        chk("str_drain_valid", bus.o_valid_d, 1'b0);
        chk("str_drain_pc", bus.o_pc_d, 64'h0);

        // Stall during a stream
        offer(1'b1, 64'h0, NOE);
        tick();
        offer(1'b1, 64'h4, NOE);
        tick();
        chk("stl_head0", bus.o_pc_d, 64'h4);
        offer(1'b1, 64'h8, NOE);
        bus.i_ready_d = 1'b0;
        tick();
`ifdef IF_ID_SKID_EN
        chk("stl_count", bus.o_count, 2'd2);
`else
        chk("stl_count", bus.o_count, 2'd1);
`endif
        chk("stl_ready", bus.o_ready_f, 1'b0);
        chk("stl_hold1", bus.o_pc_d, 64'h4);
        offer(1'b1, 64'hC, NOE);
        tick();
        tick();
        chk("stl_hold3", bus.o_pc_d, 64'h4);
        chk("stl_ready3", bus.o_ready_f, 1'b0);
        offer(1'b0, 64'h0, NOE);
        bus.i_ready_d = 1'b1;
        tick();
`ifdef IF_ID_SKID_EN
        chk("stl_rel_pc", bus.o_pc_d, 64'h8);
        chk("stl_rel_count", bus.o_count, 2'd1);
        tick();
`endif
        chk("stl_empty", bus.o_valid_d, 1'b0);
        chk("stl_empty_count", bus.o_count, 2'd0);

        // Exception lock
        bus.i_ready_d = 1'b0;
        offer(1'b1, 64'h10, 4'h1);
        tick();
        chk("exc_lock", bus.o_exc_lock, 1'b1);
        chk("exc_ready", bus.o_ready_f, 1'b0);
        chk("exc_pc", bus.o_pc_d, 64'h10);
        chk("exc_code", bus.o_exception_code_d, 4'h1);
        offer(1'b1, 64'h14, NOE);
        tick();
        chk("exc_hold_count", bus.o_count, 2'd1);
        chk("exc_hold_pc", bus.o_pc_d, 64'h10);
        bus.i_ready_d = 1'b1;
        tick();
        chk("exc_drain_valid", bus.o_valid_d, 1'b0);
        chk("exc_drain_lock", bus.o_exc_lock, 1'b1);
        tick();
        chk("exc_reject_valid", bus.o_valid_d, 1'b0);
        chk("exc_reject_ready", bus.o_ready_f, 1'b0);

        // Flush clears the lock, then flush while accepting
        offer(1'b0, 64'h0, NOE);
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        chk("fl_unlock", bus.o_exc_lock, 1'b0);
        chk("fl_ready", bus.o_ready_f, 1'b1);
        bus.i_ready_d = 1'b0;
        offer(1'b1, 64'h18, NOE);
        tick();
        chk("fl_pre_count", bus.o_count, 2'd1);
        offer(1'b1, 64'h20, 4'h3);
        bus.i_ready_d = 1'b1;
        bus.i_flush   = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        offer(1'b0, 64'h0, NOE);
        chk("fl_count", bus.o_count, 2'd0);
        chk("fl_valid", bus.o_valid_d, 1'b0);
        chk("fl_lock", bus.o_exc_lock, 1'b0);
        chk("fl_pc", bus.o_pc_d, 64'h0);
        chk("fl_exc", bus.o_exception_code_d, NOE);
        tick();
        chk("fl_after_valid", bus.o_valid_d, 1'b0);

        // Clock enable freeze, then exception-entry flush
        bus.i_ready_d = 1'b0;
        offer(1'b1, 64'h30, NOE);
        tick();
        chk("ce_load", bus.o_pc_d, 64'h30);
        bus.i_clk_en  = 1'b0;
        bus.i_ready_d = 1'b1;
        offer(1'b1, 64'h34, NOE);
        tick();
        tick();
        chk("ce_frz_pc", bus.o_pc_d, 64'h30);
        chk("ce_frz_count", bus.o_count, 2'd1);
        chk("ce_frz_valid", bus.o_valid_d, 1'b1);
        bus.i_flush_exception_m = 1'b1;
        tick();
        bus.i_flush_exception_m = 1'b0;
        chk("ce_flm_count", bus.o_count, 2'd0);
        chk("ce_flm_pc", bus.o_pc_d, 64'h0);
        bus.i_clk_en = 1'b1;
        offer(1'b0, 64'h0, NOE);

        // Asynchronous reset with a filled buffer
        bus.i_ready_d = 1'b0;
        offer(1'b1, 64'h40, NOE);
        tick();
        offer(1'b1, 64'h44, NOE);
        tick();
`ifdef IF_ID_SKID_EN
        chk("ar_fill", bus.o_count, 2'd2);
`else
        chk("ar_fill", bus.o_count, 2'd1);
`endif
        offer(1'b0, 64'h0, NOE);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", bus.o_valid_d, 1'b0);
        chk("ar_count", bus.o_count, 2'd0);
        chk("ar_pc", bus.o_pc_d, 64'h0);
        chk("ar_exc", bus.o_exception_code_d, NOE);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_post_valid", bus.o_valid_d, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
